mem_port_arbiter: RTL and testbench

//  Shares one slow-memory (or L2) port between the I-cache and D-cache miss/writeback

---
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one slow-memory (or L2) port between the I-cache and D-cache
// miss/writeback interfaces. Each cache keeps its own slow_memory-style
// handshake: it holds a read or write request level until it sees a
// one-cycle ready pulse.
//
// Arbitration is fixed D-priority with a starvation guard for I. At most one
// downstream transaction is in flight, and there is always one IDLE cycle
// between transactions. A 10-bit watchdog abandons a grant that never gets a
// ready and raises a sticky timeout flag.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   mem_read_I / mem_write_I       I-cache request levels
//   mem_addr_I / mem_wdata_I       I-cache line address / write data
//   mem_rdata_I / mem_ready_I      read data / completion pulse to the I-cache
//   mem_*_D                        the same set of ports for the D-cache
//   mem_read / mem_write           downstream request (write wins if both set)
//   mem_addr / mem_wdata           downstream line address / write data
//   mem_rdata / mem_ready          downstream read data / completion pulse
//   timeout_err                    sticky grant-timeout flag, cleared by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W       = 28,
   parameter int DATA_W       = 128,
   parameter int MAX_CONSEC_D = 4,
   parameter int TIMEOUT      = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   // I-cache side
   input  logic              mem_read_I,
   input  logic              mem_write_I,
   input  logic [ADDR_W-1:0] mem_addr_I,
   input  logic [DATA_W-1:0] mem_wdata_I,
   output logic [DATA_W-1:0] mem_rdata_I,
   output logic              mem_ready_I,
   // D-cache side
   input  logic              mem_read_D,
   input  logic              mem_write_D,
   input  logic [ADDR_W-1:0] mem_addr_D,
   input  logic [DATA_W-1:0] mem_wdata_D,
   output logic [DATA_W-1:0] mem_rdata_D,
   output logic              mem_ready_D,
   // downstream memory port
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   // status
   output logic              timeout_err
);

   localparam int STREAK_W = $clog2(MAX_CONSEC_D + 1);
   localparam int WD_W     = 10;

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CONSEC_D);
   localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1'b1);
   localparam logic [WD_W-1:0]     WD_LIMIT   = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0]     WD_ONE     = WD_W'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_I = 2'd1,
      ST_GNT_D = 2'd2
   } state_t;

   state_t              state_r;
   logic [STREAK_W-1:0] d_streak_r;     // consecutive D grants taken while I waited
   logic [WD_W-1:0]     wd_cnt_r;       // grant cycles spent without a ready
   logic                timeout_err_r;

   logic                req_i_s;
   logic                req_d_s;
   logic                i_starved_s;
   logic                pick_d_s;
   logic                pick_i_s;
   logic                gnt_req_s;      // the granted side still requests
   logic [WD_W-1:0]     wd_next_s;
   logic                wd_expire_s;

   // Request decode and the IDLE-state arbitration decision.
   always_comb begin
      req_i_s     = mem_read_I | mem_write_I;
      req_d_s     = mem_read_D | mem_write_D;
      // D normally wins; once it has taken MAX_CONSEC_D grants in a row
      // while I waited, I gets the next one.
      i_starved_s = req_i_s && (d_streak_r == STREAK_MAX);
      pick_d_s    = req_d_s && !i_starved_s;
      pick_i_s    = req_i_s && !pick_d_s;
   end

   // Status of the current grant: is the owner still asking, and is the
   // watchdog about to run out on this cycle.
   always_comb begin
      gnt_req_s = 1'b0;
      case (state_r)
         ST_GNT_I: gnt_req_s = req_i_s;
         ST_GNT_D: gnt_req_s = req_d_s;
         default:  gnt_req_s = 1'b0;
      endcase
      // wd_cnt_r is 0 in the first grant cycle, so the limit is hit at the
      // end of grant cycle number TIMEOUT.
      wd_next_s   = wd_cnt_r + WD_ONE;
      wd_expire_s = (wd_next_s == WD_LIMIT);
   end

   // Downstream mux and ready routing. Everything is decoded from the
   // registered state, so an async reset zeroes the port immediately.
   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = {ADDR_W{1'b0}};
      mem_wdata   = {DATA_W{1'b0}};
      mem_ready_I = 1'b0;
      mem_ready_D = 1'b0;
      case (state_r)
         ST_GNT_I: begin
            // A write+read request is forwarded as a write only.
            mem_write   = mem_write_I;
            mem_read    = mem_read_I & ~mem_write_I;
            mem_addr    = mem_addr_I;
            mem_wdata   = mem_wdata_I;
            mem_ready_I = mem_ready;
         end
         ST_GNT_D: begin
            mem_write   = mem_write_D;
            mem_read    = mem_read_D & ~mem_write_D;
            mem_addr    = mem_addr_D;
            mem_wdata   = mem_wdata_D;
            mem_ready_D = mem_ready;
         end
         default: begin
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            mem_addr    = {ADDR_W{1'b0}};
            mem_wdata   = {DATA_W{1'b0}};
            mem_ready_I = 1'b0;
            mem_ready_D = 1'b0;
         end
      endcase
   end

   // Read data goes to both caches; only the ready strobe qualifies it.
   assign mem_rdata_I = mem_rdata;
   assign mem_rdata_D = mem_rdata;
   assign timeout_err = timeout_err_r;

   // Arbiter FSM with the D-streak counter, watchdog and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         d_streak_r    <= {STREAK_W{1'b0}};
         wd_cnt_r      <= {WD_W{1'b0}};
         timeout_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               wd_cnt_r <= {WD_W{1'b0}};
               if (pick_d_s) begin
                  state_r <= ST_GNT_D;
                  // The streak only measures how long I has been kept waiting.
                  if (req_i_s) begin
                     if (d_streak_r != STREAK_MAX) begin
                        d_streak_r <= d_streak_r + STREAK_ONE;
                     end else begin
                        d_streak_r <= d_streak_r;
                     end
                  end else begin
                     d_streak_r <= {STREAK_W{1'b0}};
                  end
               end else if (pick_i_s) begin
                  state_r    <= ST_GNT_I;
                  d_streak_r <= {STREAK_W{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_GNT_I, ST_GNT_D: begin
               // Completion or an abandoned request both end the grant; a
               // ready in the same cycle as expiry counts as completion.
               if (mem_ready || !gnt_req_s) begin
                  state_r  <= ST_IDLE;
                  wd_cnt_r <= {WD_W{1'b0}};
               end else if (wd_expire_s) begin
                  // Drop the stalled grant; normal arbitration retries it.
                  state_r       <= ST_IDLE;
                  wd_cnt_r      <= {WD_W{1'b0}};
                  timeout_err_r <= 1'b1;
               end else begin
                  wd_cnt_r <= wd_next_s;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               wd_cnt_r <= {WD_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two cache-side drivers replay transaction queues; a memory model answers
// with random latency. Every issued transaction pushes its expected response
// into a per-side scoreboard queue, and a negedge monitor pops and compares
// whenever a cache receives a ready. A transaction-level arbitration model
// predicts the owner of each new grant from the requests pending in the
// IDLE cycle. I-side addresses have bit 27 clear, D-side addresses set, so
// ownership of the downstream port is visible from mem_addr.
// Cycle timing: posedge, memory model at +1, drivers at +3, monitor at negedge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int MAX_D = 4;

   typedef struct packed {
      logic         rd;
      logic         wr;
      logic [27:0]  addr;
      logic [127:0] wdata;
   } txn_t;

   typedef struct packed {
      logic         is_wr;
      logic [27:0]  addr;
      logic [127:0] data;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         rd_s    [2];
   logic         wr_s    [2];
   logic [27:0]  addr_s  [2];
   logic [127:0] wdata_s [2];
   logic [127:0] mem_rdata_I, mem_rdata_D, mem_rdata;
   logic         mem_ready_I, mem_ready_D, mem_ready;
   logic         mem_read, mem_write, timeout_err;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   txn_t         stim_q [2][$];
   exp_t         exp_q  [2][$];
   int           pred_q [$];     // predicted owner of the next grant: 1=I, 2=D
   int           grant_log [$];  // actual owner of each new grant
   logic [127:0] shadow  [logic [27:0]];
   logic [127:0] mem_arr [logic [27:0]];
   logic         busy [2];
   int           max_gap  = 0;
   logic         mem_stall = 1'b0;
   logic         spur      = 1'b0;

   mem_port_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_read_I  (rd_s[0]),
      .mem_write_I (wr_s[0]),
      .mem_addr_I  (addr_s[0]),
      .mem_wdata_I (wdata_s[0]),
      .mem_rdata_I (mem_rdata_I),
      .mem_ready_I (mem_ready_I),
      .mem_read_D  (rd_s[1]),
      .mem_write_D (wr_s[1]),
      .mem_addr_D  (addr_s[1]),
      .mem_wdata_D (wdata_s[1]),
      .mem_rdata_D (mem_rdata_D),
      .mem_ready_D (mem_ready_D),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] init_pat(input logic [27:0] a);
      return {4{4'h0, a}};
   endfunction

   function automatic logic [127:0] ref_read(input logic [27:0] a);
      if (shadow.exists(a)) return shadow[a];
      return init_pat(a);
   endfunction

   function automatic logic [127:0] mem_lookup(input logic [27:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return init_pat(a);
   endfunction

   function automatic int log_at(input int i);
      if (i < grant_log.size()) return grant_log[i];
      return -1;
   endfunction

   function automatic bit pending();
      return (stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
             || busy[0] || busy[1];
   endfunction

   task automatic push_txn(input int s, input logic rd, input logic wr,
                           input logic [27:0] a, input logic [127:0] wd);
      txn_t t;
      t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd;
      stim_q[s].push_back(t);
   endtask

   task automatic drain(input string nm, input int budget);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         @(negedge clk);
         n++;
      end
      chki({nm, "_drain"}, int'(pending()), 0);
      repeat (2) @(negedge clk);
   endtask

   // Memory model: answers a held downstream request after 1..4 cycles.
   initial begin
      int seen, cur_lat;
      seen = 0; cur_lat = 2;
      mem_ready = 1'b0; mem_rdata = 128'h0;
      forever begin
         @(posedge clk); #1;
         mem_ready = 1'b0;
         if (!rst_n) begin
            seen = 0;
         end else if (spur) begin
            mem_ready = 1'b1;
            spur = 1'b0;
         end else if ((mem_read || mem_write) && !mem_stall) begin
            seen++;
            if (seen >= cur_lat) begin
               mem_ready = 1'b1;
               if (mem_write) mem_arr[mem_addr] = mem_wdata;
               else mem_rdata = mem_lookup(mem_addr);
               seen = 0;
               cur_lat = int'($urandom_range(1, 4));
            end
         end else begin
            seen = 0;
         end
      end
   end

   // Cache-side drivers: hold each request until ready, release it the next cycle.
   initial begin
      logic done_pend [2];
      int   gap [2];
      txn_t t;
      exp_t e;
      for (int s = 0; s < 2; s++) begin
         rd_s[s] = 1'b0; wr_s[s] = 1'b0; addr_s[s] = 28'h0; wdata_s[s] = 128'h0;
         busy[s] = 1'b0; done_pend[s] = 1'b0; gap[s] = 0;
      end
      forever begin
         @(posedge clk); #3;
         for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
               rd_s[s] = 1'b0; wr_s[s] = 1'b0;
               busy[s] = 1'b0; done_pend[s] = 1'b0;
            end else begin
               if (busy[s]) begin
                  if (done_pend[s]) begin
                     busy[s] = 1'b0; done_pend[s] = 1'b0;
                     rd_s[s] = 1'b0; wr_s[s] = 1'b0;
                     gap[s] = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
                  end else if ((s == 0) ? mem_ready_I : mem_ready_D) begin
                     done_pend[s] = 1'b1;
                  end
               end
               if (!busy[s]) begin
                  if (gap[s] > 0) begin
                     gap[s]--;
                  end else if (stim_q[s].size() > 0) begin
                     t = stim_q[s].pop_front();
                     rd_s[s] = t.rd; wr_s[s] = t.wr; addr_s[s] = t.addr; wdata_s[s] = t.wdata;
                     e.is_wr = t.wr;
                     e.addr  = t.addr;
                     if (t.wr) begin
                        e.data = t.wdata;
                        shadow[t.addr] = t.wdata;
                     end else begin
                        e.data = ref_read(t.addr);
                     end
                     exp_q[s].push_back(e);
                     busy[s] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Monitor: scoreboard pops on ready, ready routing, idle gap, grant order.
   initial begin
      logic       active, prev_active, prev_rdy, req_i, req_d, has_e, rdy;
      logic [1:0] exp_rdy;
      int         d_run, eo, ao;
      exp_t       e;
      prev_active = 1'b0; prev_rdy = 1'b0; d_run = 0;
      forever begin
         @(negedge clk);
         active = mem_read | mem_write;
         req_i  = rd_s[0] | wr_s[0];
         req_d  = rd_s[1] | wr_s[1];
         if (!rst_n) begin
            prev_active = 1'b0; prev_rdy = 1'b0; d_run = 0;
            pred_q.delete();
         end else begin
            if (mem_ready || mem_ready_I || mem_ready_D) begin
               if (mem_ready && active) exp_rdy = mem_addr[27] ? 2'b01 : 2'b10;
               else exp_rdy = 2'b00;
               chk("ready_routing", {126'h0, mem_ready_I, mem_ready_D}, {126'h0, exp_rdy});
            end
            for (int s = 0; s < 2; s++) begin
               rdy = (s == 0) ? mem_ready_I : mem_ready_D;
               if (rdy) begin
                  has_e = exp_q[s].size() > 0;
                  chk((s == 0) ? "ready_I_expected" : "ready_D_expected", {127'h0, has_e}, 128'h1);
                  if (has_e) begin
                     e = exp_q[s].pop_front();
                     chk("addr", {100'h0, mem_addr}, {100'h0, e.addr});
                     if (e.is_wr) begin
                        chk("write_op", {126'h0, mem_read, mem_write}, 128'h1);
                        chk("wdata", mem_wdata, e.data);
                     end else begin
                        chk("read_op", {126'h0, mem_read, mem_write}, 128'h2);
                        chk("rdata", (s == 0) ? mem_rdata_I : mem_rdata_D, e.data);
                     end
                  end
               end
            end
            if (prev_rdy) chk("idle_gap", {127'h0, active}, 128'h0);
            if (pred_q.size() > 0) begin
               eo = pred_q.pop_front();
               ao = !active ? 0 : (mem_addr[27] ? 2 : 1);
               chki("grant_owner", ao, eo);
            end
            if (active && !prev_active) grant_log.push_back(mem_addr[27] ? 2 : 1);
            if (!active && (req_i || req_d)) begin
               if (req_d && !(req_i && d_run == MAX_D)) begin
                  pred_q.push_back(2);
                  d_run = req_i ? d_run + 1 : 0;
               end else begin
                  pred_q.push_back(1);
                  d_run = 0;
               end
            end
            prev_active = active;
            prev_rdy    = mem_ready_I | mem_ready_D;
         end
      end
   end

   // Global time limit.
   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
      $fatal(1, "timeout");
   end

   // Directed scenarios followed by a random mix.
   initial begin
      int           n, cnt;
      logic         err_early;
      int           t3_exp [7];
      logic [27:0]  a;
      logic [1:0]   kind;
      int           side;

      t3_exp = '{2, 2, 2, 2, 1, 2, 2};
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mem_read",    {127'h0, mem_read},    128'h0);
      chk("rst_mem_write",   {127'h0, mem_write},   128'h0);
      chk("rst_mem_addr",    {100'h0, mem_addr},    128'h0);
      chk("rst_mem_wdata",   mem_wdata,             128'h0);
      chk("rst_ready",       {126'h0, mem_ready_I, mem_ready_D}, 128'h0);
      chk("rst_timeout_err", {127'h0, timeout_err}, 128'h0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_rst", {126'h0, mem_read, mem_write}, 128'h0);

      // Lone I read.
      grant_log.delete();
      push_txn(0, 1'b1, 1'b0, 28'h0000010, 128'h0);
      drain("t1", 100);
      chki("t1_grants", grant_log.size(), 1);
      chki("t1_owner", log_at(0), 1);

      // I and D raised together: D first, then I.
      grant_log.delete();
      push_txn(0, 1'b1, 1'b0, 28'h0000011, 128'h0);
      push_txn(1, 1'b1, 1'b0, {1'b1, 27'h11}, 128'h0);
      drain("t2", 100);
      chki("t2_grants", grant_log.size(), 2);
      chki("t2_first", log_at(0), 2);
      chki("t2_second", log_at(1), 1);

      // D streaming with I pending: four D grants, one I grant, then D again.
      grant_log.delete();
      push_txn(0, 1'b1, 1'b0, 28'h0000012, 128'h0);
      for (int i = 0; i < 6; i++) push_txn(1, 1'b1, 1'b0, {1'b1, 24'h0, 3'(i)}, 128'h0);
      drain("t3", 300);
      chki("t3_grants", grant_log.size(), 7);
      for (int i = 0; i < 7; i++) chki($sformatf("t3_grant%0d", i), log_at(i), t3_exp[i]);

      // D read+write together: forwarded as a write.
      a = {1'b1, 27'h20};
      push_txn(1, 1'b1, 1'b1, a, {16{8'hA5}});
      drain("t4w", 100);
      chk("t4_mem_content", mem_lookup(a), {16{8'hA5}});
      push_txn(1, 1'b1, 1'b0, a, 128'h0);
      drain("t4r", 100);

      // Ready pulse while idle reaches neither cache.
      spur = 1'b1;
      @(negedge clk);
      chk("spurious_ready", {126'h0, mem_ready_I, mem_ready_D}, 128'h0);
      repeat (2) @(negedge clk);

      // Random mix.
      max_gap = 2;
      for (int i = 0; i < 300; i++) begin
         side = int'($urandom_range(0, 1));
         kind = 2'($urandom_range(0, 3));
         a    = {side[0], 24'h0, 3'($urandom_range(0, 7))};
         push_txn(side, kind != 2'd2, kind[1], a, {$urandom, $urandom, $urandom, $urandom});
      end
      drain("rand", 6000);
      max_gap = 0;

      // Memory never answers: watchdog after 1023 grant cycles, then re-grant.
      mem_stall = 1'b1;
      push_txn(0, 1'b1, 1'b0, 28'h0000005, 128'h0);
      n = 0;
      while (mem_read !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      cnt = 0; err_early = 1'b0;
      while (mem_read === 1'b1 && cnt < 1100) begin
         cnt++;
         if (timeout_err !== 1'b0) err_early = 1'b1;
         @(negedge clk);
      end
      chki("t5_grant_cycles", cnt, 1023);
      chk("t5_err_early", {127'h0, err_early}, 128'h0);
      chk("t5_err_set", {127'h0, timeout_err}, 128'h1);
      chk("t5_idle", {127'h0, mem_read}, 128'h0);
      @(negedge clk);
      chk("t5_regrant", {127'h0, mem_read}, 128'h1);
      repeat (20) @(negedge clk);
      mem_stall = 1'b0;
      drain("t5", 100);
      chk("t5_err_sticky", {127'h0, timeout_err}, 128'h1);

      // Async reset in the middle of a D grant.
      mem_stall = 1'b1;
      push_txn(1, 1'b1, 1'b0, {1'b1, 27'h33}, 128'h0);
      n = 0;
      while (mem_read !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_read",  {126'h0, mem_read, mem_write}, 128'h0);
      chk("t6_addr",  {100'h0, mem_addr}, 128'h0);
      chk("t6_ready", {126'h0, mem_ready_I, mem_ready_D}, 128'h0);
      chk("t6_err_cleared", {127'h0, timeout_err}, 128'h0);
      stim_q[0].delete(); stim_q[1].delete();
      exp_q[0].delete();  exp_q[1].delete();
      mem_stall = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_hold_read", {126'h0, mem_read, mem_write}, 128'h0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("t6_idle_after", {126'h0, mem_read, mem_write}, 128'h0);
      grant_log.delete();
      push_txn(0, 1'b1, 1'b0, 28'h0000012, 128'h0);
      push_txn(1, 1'b0, 1'b1, {1'b1, 27'h34}, {4{32'hC0FFEE01}});
      drain("t6_post", 100);
      chki("t6_post_first", log_at(0), 2);
      chki("t6_post_second", log_at(1), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
